tetris_ctrl_fsm: RTL and testbench
==================================

# tetris_ctrl_fsm

Parametrised game-control sequencer for the Tetris core; the next generation of the original game state machine. It arbitrates keyboard strobes and a gravity timer, issues one-cycle command pulses to the gameboard/sandbox datapath, and waits for a done handshake after each. Over the original machine it adds:

- lock delay and hard drop;
- once-per-piece hold;
- a looping multi-line clear scan;
- spawn-blocked game-over detection.

## Interface
Parameters:
- ROWS, 20: board rows; clear_row width RW = $clog2(ROWS).
- GRAVITY_DIV, 1000000: clock cycles per gravity tick, minimum 2.
- LOCK_DELAY, 3: grounded gravity ticks tolerated before forced placement, minimum 1.

Ports (clock and reset first):
- Clk  in  1  system clock; one clock domain.
- RESET  in  1  synchronous, active-high reset.
- key_left, key_right, key_rotl, key_rotr, key_hold, key_drop, key_start  in  1 each  single-cycle key strobes.
- ground_notif  in  1  active piece cannot move down.
- line_full  in  1  row clear_row is full (combinational from board).
- spawn_blocked  in  1  freshly loaded piece overlaps board.
- op_done  in  1  datapath finished the last command.
- FALL, MOVELEFT, MOVERIGHT, ROTATELEFT, ROTATERIGHT, HOLDPIECE, PIECEPLACED, PIECE_LOAD, CLEARLINE, CLEARALL  out  1 each  command pulses.
- clear_row  out  RW  row under scan / to collapse.
- lines_cleared  out  3  lines cleared by last placement, 0..4.
- lines_valid  out  1  pulse; lines_cleared updated.
- game_over  out  1  high while in S_ENDGAME.

## Operation
States:
- S_ISSUE: one cycle; asserts the command selected by the internal cmd register.
- S_WAIT: holds until op_done, then goes to the cmd-specific successor.
- S_LOGO, S_STALL, S_SCAN, S_DROP_CHK, S_ENDGAME.

Command protocol:
- Exactly one command pulse is high per S_ISSUE cycle. All command pulses are 0 in every other state.
- op_done is ignored in S_ISSUE.

Successor of each command after op_done:
- CLEARALL → S_LOGO.
- PIECE_LOAD → S_ENDGAME if spawn_blocked, else S_STALL. On this transition hold_used and lock_cnt clear.
- MOVE*/ROTATE*/HOLDPIECE → S_STALL.
- FALL → S_STALL, or S_DROP_CHK when drop mode is active.
- PIECEPLACED → S_SCAN with clear_row = ROWS-1 and line count 0. hold_used clears.
- CLEARLINE → S_SCAN, same row, count+1.

S_LOGO:
- key_start → issue PIECE_LOAD.
- Other keys are ignored.

S_STALL arbitration, highest priority first:
1. Gravity pending (see gravity rules below).
2. key_drop.
3. key_hold — taken only if hold_used is 0; then sets hold_used. If hold_used is 1, key_hold is ignored.
4. key_rotr.
5. key_rotl.
6. key_right.
7. key_left.

Key strobes arriving outside S_STALL, or losing arbitration, are dropped (no queue).

Gravity and lock:
- Gravity pending when ground_notif=0 → issue FALL.
- Gravity pending when ground_notif=1 → lock_cnt+1; if lock_cnt+1 == LOCK_DELAY → issue PIECEPLACED, else stay in S_STALL.
- A gravity tick with ground_notif=0 clears lock_cnt.
- Moves and rotations do not reset lock_cnt.

Hard drop:
- key_drop sets drop mode and goes to S_DROP_CHK.
- S_DROP_CHK: ground_notif=1 → clear drop mode, issue PIECEPLACED; else issue FALL.

S_SCAN (one row per cycle):
- line_full=1 → issue CLEARLINE with current clear_row.
- line_full=0 and clear_row>0 → clear_row-1.
- line_full=0 and clear_row=0 → pulse lines_valid, load lines_cleared (saturating at 4), issue PIECE_LOAD.

S_ENDGAME:
- game_over=1.
- key_start → issue CLEARALL.

## Timing
Gravity counter:
- Counts 0..GRAVITY_DIV-1 only in S_STALL/S_ISSUE/S_WAIT/S_DROP_CHK during play; frozen in S_LOGO/S_ENDGAME/S_SCAN.
- On wrap it sets grav_pending.
- grav_pending clears when serviced in S_STALL. Multiple wraps while pending collapse to one.
- Counter and grav_pending clear on PIECE_LOAD completion.

Latencies:
- Key → command pulse: 1 cycle (strobe in S_STALL at cycle t, pulse at t+1).
- Minimum command round trip: 3 cycles (issue, wait with op_done, back in S_STALL).

Reset (synchronous, any state, including mid-wait or mid-scan):
- Next state is S_ISSUE with cmd=CLEARALL, so CLEARALL is high in the first cycle after RESET falls.
- While RESET is high, all outputs are 0, clear_row=ROWS-1, lines_cleared=0, lines_valid=0, game_over=0.
- Counters, lock_cnt, hold_used and drop mode are 0.

Simultaneous events:
- op_done together with a key: the key is dropped.
- line_full is sampled only in S_SCAN.

## Test plan
- Reset release, op_done 2 cycles later → CLEARALL at cycle 1 only, state S_LOGO; key_start → PIECE_LOAD pulse next cycle.
- GRAVITY_DIV=8, no keys, ground_notif=0, op_done same cycle as wait → FALL pulses every 8 cycles. Raise ground_notif with LOCK_DELAY=3 → no FALL; PIECEPLACED on the 3rd grounded tick.
- key_hold twice in one piece → one HOLDPIECE. After placement and load, key_hold → HOLDPIECE again.
- key_drop with ground_notif rising after the 4th FALL → exactly 4 FALL pulses, then PIECEPLACED.
- Scan with rows 19 and 18 full → CLEARLINE with clear_row=19 twice (collapse refill), scan continues to 0, lines_valid with lines_cleared=2, then PIECE_LOAD.
- PIECE_LOAD done with spawn_blocked=1 → game_over=1. key_start → CLEARALL, then S_LOGO. RESET asserted mid-S_SCAN → CLEARALL after release, lines_cleared=0.

Source files
------------

// File: rtl/tetris_ctrl_fsm.sv
// Game-control sequencer: arbitrates keys and gravity, issues one-cycle command
// pulses to the board datapath and waits for op_done after each one.
module tetris_ctrl_fsm #(
    parameter int ROWS        = 20,
    parameter int GRAVITY_DIV = 1000000,
    parameter int LOCK_DELAY  = 3,
    localparam int RW         = $clog2(ROWS)
) (
    input  logic          Clk,
    input  logic          RESET,
    input  logic          key_left,
    input  logic          key_right,
    input  logic          key_rotl,
    input  logic          key_rotr,
    input  logic          key_hold,
    input  logic          key_drop,
    input  logic          key_start,
    input  logic          ground_notif,
    input  logic          line_full,
    input  logic          spawn_blocked,
    input  logic          op_done,
    output logic          FALL,
    output logic          MOVELEFT,
    output logic          MOVERIGHT,
    output logic          ROTATELEFT,
    output logic          ROTATERIGHT,
    output logic          HOLDPIECE,
    output logic          PIECEPLACED,
    output logic          PIECE_LOAD,
    output logic          CLEARLINE,
    output logic          CLEARALL,
    output logic [RW-1:0] clear_row,
    output logic [2:0]    lines_cleared,
    output logic          lines_valid,
    output logic          game_over
);

    localparam int GW = $clog2(GRAVITY_DIV);
    localparam int LW = $clog2(LOCK_DELAY + 1);
    localparam logic [GW-1:0] GRAV_MAX = GW'(GRAVITY_DIV - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_DELAY);
    localparam logic [RW-1:0] ROW_TOP  = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_ISSUE, S_WAIT, S_LOGO, S_STALL, S_SCAN, S_DROP_CHK, S_ENDGAME
    } state_t;

    typedef enum logic [3:0] {
        C_FALL, C_LEFT, C_RIGHT, C_ROTL, C_ROTR, C_HOLD,
        C_PLACE, C_LOAD, C_CLRLINE, C_CLRALL
    } cmd_t;

    state_t        state, state_d;
    cmd_t          cmd, cmd_d;
    logic [RW-1:0] row, row_d;
    logic [2:0]    line_cnt, line_cnt_d;
    logic [2:0]    lines_q, lines_d;
    logic          lv_q, lv_d;
    logic [LW-1:0] lock_cnt, lock_d;
    logic          hold_used, hold_d;
    logic          drop_mode, drop_d;
    logic [GW-1:0] grav_cnt, grav_cnt_d;
    logic          grav_pend, grav_pend_d;
    logic          grav_run, grav_wrap;

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state     <= S_ISSUE;
            cmd       <= C_CLRALL;
            row       <= ROW_TOP;
            line_cnt  <= '0;
            lines_q   <= '0;
            lv_q      <= 1'b0;
            lock_cnt  <= '0;
            hold_used <= 1'b0;
            drop_mode <= 1'b0;
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            state     <= state_d;
            cmd       <= cmd_d;
            row       <= row_d;
            line_cnt  <= line_cnt_d;
            lines_q   <= lines_d;
            lv_q      <= lv_d;
            lock_cnt  <= lock_d;
            hold_used <= hold_d;
            drop_mode <= drop_d;
            grav_cnt  <= grav_cnt_d;
            grav_pend <= grav_pend_d;
        end
    end

    // Gravity only advances while a piece is in play; logo, scan and endgame freeze it.
    assign grav_run  = (state == S_STALL) || (state == S_ISSUE) ||
                       (state == S_WAIT)  || (state == S_DROP_CHK);
    assign grav_wrap = grav_run && (grav_cnt == GRAV_MAX);

    always_comb begin
        state_d     = state;
        cmd_d       = cmd;
        row_d       = row;
        line_cnt_d  = line_cnt;
        lines_d     = lines_q;
        lv_d        = 1'b0;
        lock_d      = lock_cnt;
        hold_d      = hold_used;
        drop_d      = drop_mode;
        grav_cnt_d  = grav_run ? (grav_wrap ? '0 : grav_cnt + 1'b1) : grav_cnt;
        grav_pend_d = grav_pend | grav_wrap;

        unique case (state)
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (op_done) begin
                    unique case (cmd)
                        C_CLRALL: state_d = S_LOGO;
                        C_LOAD: begin
                            hold_d      = 1'b0;
                            lock_d      = '0;
                            grav_cnt_d  = '0;
                            grav_pend_d = 1'b0;
                            state_d     = spawn_blocked ? S_ENDGAME : S_STALL;
                        end
                        C_FALL: state_d = drop_mode ? S_DROP_CHK : S_STALL;
                        C_PLACE: begin
                            row_d      = ROW_TOP;
                            line_cnt_d = '0;
                            hold_d     = 1'b0;
                            state_d    = S_SCAN;
                        end
                        C_CLRLINE: begin
                            line_cnt_d = (line_cnt == 3'd4) ? 3'd4 : line_cnt + 1'b1;
                            state_d    = S_SCAN;
                        end
                        default: state_d = S_STALL;
                    endcase
                end
            end
            S_LOGO: begin
                if (key_start) begin
                    cmd_d   = C_LOAD;
                    state_d = S_ISSUE;
                end
            end
            S_STALL: begin
                if (grav_pend) begin
                    // A wrap in the servicing cycle is a fresh tick and stays pending.
                    grav_pend_d = grav_wrap;
                    if (!ground_notif) begin
                        lock_d  = '0;
                        cmd_d   = C_FALL;
                        state_d = S_ISSUE;
                    end else begin
                        lock_d = lock_cnt + 1'b1;
                        if (lock_cnt + 1'b1 == LOCK_MAX) begin
                            cmd_d   = C_PLACE;
                            state_d = S_ISSUE;
                        end
                    end
                end else if (key_drop) begin
                    drop_d  = 1'b1;
                    state_d = S_DROP_CHK;
                end else if (key_hold && !hold_used) begin
                    hold_d  = 1'b1;
                    cmd_d   = C_HOLD;
                    state_d = S_ISSUE;
                end else if (key_rotr) begin
                    cmd_d   = C_ROTR;
                    state_d = S_ISSUE;
                end else if (key_rotl) begin
                    cmd_d   = C_ROTL;
                    state_d = S_ISSUE;
                end else if (key_right) begin
                    cmd_d   = C_RIGHT;
                    state_d = S_ISSUE;
                end else if (key_left) begin
                    cmd_d   = C_LEFT;
                    state_d = S_ISSUE;
                end
            end
            S_DROP_CHK: begin
                state_d = S_ISSUE;
                if (ground_notif) begin
                    drop_d = 1'b0;
                    cmd_d  = C_PLACE;
                end else begin
                    cmd_d = C_FALL;
                end
            end
            S_SCAN: begin
                // A cleared row is rescanned: the collapse may have pulled another full row into it.
                if (line_full) begin
                    cmd_d   = C_CLRLINE;
                    state_d = S_ISSUE;
                end else if (row != '0) begin
                    row_d = row - 1'b1;
                end else begin
                    lv_d    = 1'b1;
                    lines_d = line_cnt;
                    cmd_d   = C_LOAD;
                    state_d = S_ISSUE;
                end
            end
            S_ENDGAME: begin
                if (key_start) begin
                    cmd_d   = C_CLRALL;
                    state_d = S_ISSUE;
                end
            end
            default: begin
                cmd_d   = C_CLRALL;
                state_d = S_ISSUE;
            end
        endcase
    end

    logic issue;
    assign issue = (state == S_ISSUE) && !RESET;

    assign FALL          = issue && (cmd == C_FALL);
    assign MOVELEFT      = issue && (cmd == C_LEFT);
    assign MOVERIGHT     = issue && (cmd == C_RIGHT);
    assign ROTATELEFT    = issue && (cmd == C_ROTL);
    assign ROTATERIGHT   = issue && (cmd == C_ROTR);
    assign HOLDPIECE     = issue && (cmd == C_HOLD);
    assign PIECEPLACED   = issue && (cmd == C_PLACE);
    assign PIECE_LOAD    = issue && (cmd == C_LOAD);
    assign CLEARLINE     = issue && (cmd == C_CLRLINE);
    assign CLEARALL      = issue && (cmd == C_CLRALL);
    assign clear_row     = row;
    assign lines_cleared = lines_q;
    assign lines_valid   = lv_q && !RESET;
    assign game_over     = (state == S_ENDGAME) && !RESET;

endmodule

// File: tb/tb_tetris_ctrl_fsm.sv
// Directed bench for tetris_ctrl_fsm with ROWS=20, GRAVITY_DIV=8, LOCK_DELAY=3.
module tb_tetris_ctrl_fsm;

    localparam int I_FALL = 0, I_LEFT = 1, I_RIGHT = 2, I_ROTL = 3, I_ROTR = 4;
    localparam int I_HOLD = 5, I_PLACE = 6, I_LOAD = 7, I_CLRLINE = 8, I_CLRALL = 9;

    logic Clk = 1'b0;
    logic RESET = 1'b1;
    logic key_left = 0, key_right = 0, key_rotl = 0, key_rotr = 0;
    logic key_hold = 0, key_drop = 0, key_start = 0;
    logic ground_notif = 0, spawn_blocked = 0, op_done = 0;
    logic line_full;
    logic FALL, MOVELEFT, MOVERIGHT, ROTATELEFT, ROTATERIGHT, HOLDPIECE;
    logic PIECEPLACED, PIECE_LOAD, CLEARLINE, CLEARALL;
    logic [4:0] clear_row;
    logic [2:0] lines_cleared;
    logic lines_valid, game_over;
    logic [9:0] cmds;
    logic [19:0] full_rows = '0;

    int checks = 0;
    int failures = 0;
    int n, f, ncl, fcnt;

    always #5 Clk = ~Clk;

    assign cmds = {CLEARALL, CLEARLINE, PIECE_LOAD, PIECEPLACED, HOLDPIECE,
                   ROTATERIGHT, ROTATELEFT, MOVERIGHT, MOVELEFT, FALL};
    assign line_full = full_rows[clear_row];

    tetris_ctrl_fsm #(.ROWS(20), .GRAVITY_DIV(8), .LOCK_DELAY(3)) dut (
        .Clk(Clk), .RESET(RESET),
        .key_left(key_left), .key_right(key_right), .key_rotl(key_rotl),
        .key_rotr(key_rotr), .key_hold(key_hold), .key_drop(key_drop),
        .key_start(key_start), .ground_notif(ground_notif), .line_full(line_full),
        .spawn_blocked(spawn_blocked), .op_done(op_done),
        .FALL(FALL), .MOVELEFT(MOVELEFT), .MOVERIGHT(MOVERIGHT),
        .ROTATELEFT(ROTATELEFT), .ROTATERIGHT(ROTATERIGHT), .HOLDPIECE(HOLDPIECE),
        .PIECEPLACED(PIECEPLACED), .PIECE_LOAD(PIECE_LOAD), .CLEARLINE(CLEARLINE),
        .CLEARALL(CLEARALL), .clear_row(clear_row), .lines_cleared(lines_cleared),
        .lines_valid(lines_valid), .game_over(game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Cycles until command idx pulses (-1 on timeout); FALL pulses seen before it are counted.
    task automatic wait_pulse(input int idx, input int limit, output int cyc, output int falls);
        cyc = -1;
        falls = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge Clk);
            if (cmds[idx]) begin
                cyc = i;
                break;
            end
            if (cmds[I_FALL]) falls++;
        end
    endtask

    // Follows a scan to its PIECE_LOAD, collapsing the board model on every CLEARLINE.
    task automatic run_scan(input int limit, input int exp_row, output int cyc, output int nclr);
        cyc = -1;
        nclr = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge Clk);
            if (cmds[I_CLRLINE]) begin
                nclr++;
                chk("clearline_row", clear_row, exp_row);
                for (int r = int'(clear_row); r > 0; r--) full_rows[r] = full_rows[r-1];
                full_rows[0] = 1'b0;
            end
            if (cmds[I_LOAD]) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(); step();
        chk("rst_cmds", cmds, 0);
        chk("rst_clear_row", clear_row, 19);
        chk("rst_lines_cleared", lines_cleared, 0);
        chk("rst_lines_valid", lines_valid, 0);
        chk("rst_game_over", game_over, 0);

        // Release: CLEARALL in the first cycle, op_done two cycles later
        RESET = 1'b0; #1;
        chk("clearall_first", cmds, 10'h200);
        step(); chk("clearall_once_c2", cmds, 0);
        step(); op_done = 1'b1; chk("clearall_once_c3", cmds, 0);
        step(); chk("logo_idle", cmds, 0); chk("logo_no_gameover", game_over, 0);
        key_start = 1; key_left = 1;
        step(); key_start = 0; key_left = 0;
        chk("start_load", cmds, 10'h080);

        // Gravity: first FALL 11 cycles after the load pulse, then every 8
        wait_pulse(I_FALL, 20, n, f); chk("first_fall_lat", n, 11);
        wait_pulse(I_FALL, 20, n, f); chk("fall_period", n, 8);
        ground_notif = 1;
        wait_pulse(I_PLACE, 40, n, f);
        chk("lock_place_lat", n, 24);
        chk("lock_no_fall", f, 0);

        run_scan(40, 19, n, ncl);
        chk("empty_scan_len", n, 22);
        chk("empty_scan_clears", ncl, 0);
        chk("empty_lines_valid", lines_valid, 1);
        chk("empty_lines_cleared", lines_cleared, 0);
        ground_notif = 0;

        // Hold once per piece, key priorities, dropped strobes
        step(); chk("lines_valid_pulse", lines_valid, 0); key_right = 1;
        step(); key_right = 0; chk("key_in_wait_dropped", cmds, 0); key_hold = 1;
        step(); key_hold = 0; chk("hold_first", cmds, 10'h020);
        step();
        step(); key_hold = 1; key_left = 1;
        step(); key_hold = 0; key_left = 0; chk("hold_used_left", cmds, 10'h002);
        step();
        step(); key_rotr = 1; key_rotl = 1; key_right = 1;
        step(); key_rotr = 0; key_rotl = 0; key_right = 0; chk("rotr_priority", cmds, 10'h010);
        step();
        step(); key_drop = 1;
        step(); key_drop = 0; chk("gravity_beats_drop", cmds, 10'h001);
        step();
        step(); key_drop = 1;

        // Hard drop: four FALLs, ground after the 4th, then PIECEPLACED
        fcnt = 0; n = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            key_drop = 0;
            if (FALL) begin
                fcnt++;
                if (fcnt == 4) ground_notif = 1;
            end
            if (PIECEPLACED) begin
                n = i;
                break;
            end
        end
        chk("drop_place_lat", n, 14);
        chk("drop_fall_count", fcnt, 4);

        // Rows 19 and 18 full: two clears at row 19, then a full scan
        full_rows = 20'hC0000;
        run_scan(40, 19, n, ncl);
        chk("scan2_len", n, 28);
        chk("scan2_clears", ncl, 2);
        chk("scan2_lines_valid", lines_valid, 1);
        chk("scan2_lines_cleared", lines_cleared, 2);
        ground_notif = 0;
        step(); chk("scan2_valid_pulse", lines_valid, 0);
        step(); key_hold = 1;
        step(); key_hold = 0; chk("hold_new_piece", cmds, 10'h020);
        step();
        step(); ground_notif = 1; key_drop = 1;
        step(); key_drop = 0; chk("drop_chk_idle", cmds, 0);
        wait_pulse(I_PLACE, 10, n, f); chk("grounded_drop_place", n, 1);

        // One full row at 5, then a blocked spawn
        full_rows = 20'h00020;
        run_scan(40, 5, n, ncl);
        chk("scan3_len", n, 25);
        chk("scan3_clears", ncl, 1);
        chk("scan3_lines_cleared", lines_cleared, 1);
        spawn_blocked = 1;
        step(); chk("gameover_wait", game_over, 0);
        step(); chk("gameover_set", game_over, 1); chk("endgame_cmds", cmds, 0);
        key_left = 1; key_drop = 1;
        step(); key_left = 0; key_drop = 0;
        chk("endgame_ignores_keys", cmds, 0); chk("endgame_hold", game_over, 1);
        key_start = 1;
        step(); key_start = 0; chk("endgame_clearall", cmds, 10'h200);
        spawn_blocked = 0;
        step();
        step(); chk("back_to_logo", cmds, 0); chk("logo_gameover_low", game_over, 0);

        // Reset in the middle of a scan
        key_start = 1;
        step(); key_start = 0; chk("restart_load", cmds, 10'h080);
        step();
        step(); key_drop = 1;
        step(); key_drop = 0;
        step(); chk("restart_place", cmds, 10'h040);
        step(); step(); step(); step(); step();
        chk("mid_scan_row", clear_row, 16);
        RESET = 1; #1;
        chk("rst_async_gate", cmds, 0);
        step();
        chk("midrst_clear_row", clear_row, 19);
        chk("midrst_lines_cleared", lines_cleared, 0);
        chk("midrst_lines_valid", lines_valid, 0);
        chk("midrst_game_over", game_over, 0);
        step();
        RESET = 0; #1;
        chk("midrst_clearall", cmds, 10'h200);
        step(); chk("midrst_wait", cmds, 0);
        step(); chk("midrst_logo", cmds, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
